// File: rtl/ibex_l2_regfile_ctrl_if.sv
// Request/grant bundle between the L1 register-file stage and the L2 register storage.
// The master drives requests and write data; the slave returns grants, read data and busy.
interface ibex_l2_regfile_ctrl_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 rd_a_req_i;
    logic [4:0]           rd_a_addr_i;
    logic                 rd_a_gnt_o;
    logic                 rd_a_rvalid_o;
    logic [DataWidth-1:0] rd_a_rdata_o;
    logic                 rd_b_req_i;
    logic [4:0]           rd_b_addr_i;
    logic                 rd_b_gnt_o;
    logic                 rd_b_rvalid_o;
    logic [DataWidth-1:0] rd_b_rdata_o;
    logic                 wr_req_i;
    logic [4:0]           wr_addr_i;
    logic [DataWidth-1:0] wr_data_i;
    logic                 wr_gnt_o;
    logic                 busy_o;

    modport slave (
        input  rd_a_req_i, rd_a_addr_i, rd_b_req_i, rd_b_addr_i,
               wr_req_i, wr_addr_i, wr_data_i,
        output rd_a_gnt_o, rd_a_rvalid_o, rd_a_rdata_o,
               rd_b_gnt_o, rd_b_rvalid_o, rd_b_rdata_o, wr_gnt_o, busy_o
    );

    modport master (
        output rd_a_req_i, rd_a_addr_i, rd_b_req_i, rd_b_addr_i,
               wr_req_i, wr_addr_i, wr_data_i,
        input  rd_a_gnt_o, rd_a_rvalid_o, rd_a_rdata_o,
               rd_b_gnt_o, rd_b_rvalid_o, rd_b_rdata_o, wr_gnt_o, busy_o
    );
endinterface

// File: rtl/ibex_l2_regfile_ctrl.sv
// L2 register storage behind the L1 regfile: one array access per cycle, FIFO write buffer with read forwarding.
// Define IBEX_L2RF_PERF_CNT_EN to add saturating read/write/forward counters.
module ibex_l2_regfile_ctrl #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 32,
    parameter int unsigned WbDepth   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_l2_regfile_ctrl_if.slave bus
`ifdef IBEX_L2RF_PERF_CNT_EN
    ,
    output logic [31:0]           rd_cnt_o,
    output logic [31:0]           wr_cnt_o,
    output logic [31:0]           fwd_cnt_o
`endif
);
    localparam int unsigned AW = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned PW = $clog2(WbDepth);
    localparam int unsigned CW = $clog2(WbDepth + 1);

    typedef enum logic [1:0] {IDLE, B_PEND, FULL_DRAIN} state_e;

    logic [DataWidth-1:0] mem_q     [NumWords];
    logic [AW-1:0]        wb_addr_q [WbDepth];
    logic [DataWidth-1:0] wb_data_q [WbDepth];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    state_e               state_q, ret_q, base_nxt;

    logic                 rd_a_vld_p1, rd_b_vld_p1;
    logic [DataWidth-1:0] rd_a_data_p1, rd_b_data_p1;

    logic [AW-1:0]        a_idx, b_idx, w_idx, acc_idx, fwd_pos;
    logic                 full, pend_b, drain, gnt_a, gnt_b, wr_gnt, enq;
    logic                 fwd_a_hit, fwd_b_hit;
    logic [DataWidth-1:0] fwd_a_data, fwd_b_data, arr_rdata, a_val, b_val;
    int                   p;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(WbDepth - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign a_idx  = bus.rd_a_addr_i[AW-1:0];
    assign b_idx  = bus.rd_b_addr_i[AW-1:0];
    assign w_idx  = bus.wr_addr_i[AW-1:0];
    assign full   = (count_q == CW'(WbDepth));
    assign pend_b = (state_q == B_PEND) || (state_q == FULL_DRAIN && ret_q == B_PEND);

    // A full buffer always wins the port; a pending B beats a fresh A so B cannot starve.
    always_comb begin
        drain = 1'b0;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst_ni) begin
            drain = 1'b0;
        end else if (full) begin
            drain = 1'b1;
        end else if (pend_b && bus.rd_b_req_i) begin
            gnt_b = 1'b1;
        end else if (bus.rd_a_req_i) begin
            gnt_a = 1'b1;
        end else if (bus.rd_b_req_i) begin
            gnt_b = 1'b1;
        end else if (count_q != '0) begin
            drain = 1'b1;
        end
    end

    always_comb begin
        base_nxt = IDLE;
        if (gnt_a && bus.rd_b_req_i) begin
            base_nxt = B_PEND;
        end else if (pend_b && bus.rd_b_req_i && !gnt_b) begin
            base_nxt = B_PEND;
        end
    end

    // Oldest-to-youngest scan so the youngest matching entry is the one that sticks.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        fwd_pos    = '0;
        p          = 0;
        for (int i = 0; i < int'(WbDepth); i++) begin
            p = int'(rd_ptr_q) + i;
            if (p >= int'(WbDepth)) p = p - int'(WbDepth);
            fwd_pos = AW'(p);
            if (i < int'(count_q)) begin
                if (wb_addr_q[PW'(p)] == a_idx) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = wb_data_q[PW'(p)];
                end
                if (wb_addr_q[PW'(p)] == b_idx) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = wb_data_q[PW'(p)];
                end
            end
        end
    end

    assign acc_idx   = drain ? wb_addr_q[rd_ptr_q] : (gnt_a ? a_idx : b_idx);
    assign arr_rdata = mem_q[acc_idx];
    assign a_val     = (a_idx == '0) ? '0 : (fwd_a_hit ? fwd_a_data : arr_rdata);
    assign b_val     = (b_idx == '0) ? '0 : (fwd_b_hit ? fwd_b_data : arr_rdata);

    assign wr_gnt  = rst_ni && !full;
    assign enq     = bus.wr_req_i && wr_gnt && (w_idx != '0);
    assign count_d = count_q + CW'(enq) - CW'(drain);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumWords); i++) mem_q[i] <= '0;
            for (int i = 0; i < int'(WbDepth); i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            ret_q        <= IDLE;
            rd_a_vld_p1  <= 1'b0;
            rd_b_vld_p1  <= 1'b0;
            rd_a_data_p1 <= '0;
            rd_b_data_p1 <= '0;
        end else begin
            if (drain) begin
                mem_q[wb_addr_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
                rd_ptr_q                   <= ptr_inc(rd_ptr_q);
            end
            if (enq) begin
                wb_addr_q[wr_ptr_q] <= w_idx;
                wb_data_q[wr_ptr_q] <= bus.wr_data_i;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            count_q <= count_d;
            if (count_d == CW'(WbDepth)) begin
                state_q <= FULL_DRAIN;
                ret_q   <= base_nxt;
            end else begin
                state_q <= base_nxt;
                ret_q   <= IDLE;
            end
            // p1: read response, one cycle after the grant
            rd_a_vld_p1 <= gnt_a;
            rd_b_vld_p1 <= gnt_b;
            if (gnt_a) rd_a_data_p1 <= a_val;
            if (gnt_b) rd_b_data_p1 <= b_val;
        end
    end

    assign bus.rd_a_gnt_o    = gnt_a;
    assign bus.rd_b_gnt_o    = gnt_b;
    assign bus.wr_gnt_o      = wr_gnt;
    assign bus.rd_a_rvalid_o = rd_a_vld_p1;
    assign bus.rd_b_rvalid_o = rd_b_vld_p1;
    assign bus.rd_a_rdata_o  = rd_a_data_p1;
    assign bus.rd_b_rdata_o  = rd_b_data_p1;
    assign bus.busy_o = rst_ni && ((count_q != '0) || (bus.rd_a_req_i && !gnt_a) ||
                                   (bus.rd_b_req_i && !gnt_b) || (state_q != IDLE));

`ifdef IBEX_L2RF_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
        return (inc && (c != '1)) ? c + 32'd1 : c;
    endfunction

    logic [31:0] rd_cnt_q, wr_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= sat_inc(rd_cnt_q, gnt_a || gnt_b);
            wr_cnt_q  <= sat_inc(wr_cnt_q, enq);
            fwd_cnt_q <= sat_inc(fwd_cnt_q, (gnt_a && fwd_a_hit) || (gnt_b && fwd_b_hit));
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign fwd_cnt_o = fwd_cnt_q;
`endif

    logic unused_fwd_pos;
    assign unused_fwd_pos = ^fwd_pos;
endmodule

// File: tb/tb_ibex_l2_regfile_ctrl.sv
// Bench for ibex_l2_regfile_ctrl: directed vector table, multi-cycle corner sequences,
// then random traffic compared against a queue-based reference model.
module tb_ibex_l2_regfile_ctrl;
    localparam int WB = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    ibex_l2_regfile_ctrl_if #(.DataWidth(32)) bus ();

    ibex_l2_regfile_ctrl #(.DataWidth(32), .NumWords(32), .WbDepth(WB)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic ra; logic [4:0] aa; logic rb; logic [4:0] ba;
        logic w;  logic [4:0] wa; logic [31:0] wd;
        logic [5:0] ectl;  // {gnt_a, gnt_b, wr_gnt, busy, rvalid_a, rvalid_b}
        logic [31:0] eda; logic [31:0] edb;
    } vec_t;

    function automatic vec_t mk(input logic ra, input logic [4:0] aa, input logic rb,
                                input logic [4:0] ba, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [5:0] ectl,
                                input logic [31:0] eda, input logic [31:0] edb);
        vec_t v;
        v.ra = ra; v.aa = aa; v.rb = rb; v.ba = ba; v.w = w; v.wa = wa; v.wd = wd;
        v.ectl = ectl; v.eda = eda; v.edb = edb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ra, input logic [4:0] aa, input logic rb, input logic [4:0] ba,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd);
        bus.rd_a_req_i = ra; bus.rd_a_addr_i = aa;
        bus.rd_b_req_i = rb; bus.rd_b_addr_i = ba;
        bus.wr_req_i = w; bus.wr_addr_i = wa; bus.wr_data_i = wd;
    endtask

    function automatic logic [31:0] ctl_now();
        return 32'({bus.rd_a_gnt_o, bus.rd_b_gnt_o, bus.wr_gnt_o, bus.busy_o,
                    bus.rd_a_rvalid_o, bus.rd_b_rvalid_o});
    endfunction

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        drive(v.ra, v.aa, v.rb, v.ba, v.w, v.wa, v.wd);
        @(negedge clk);
        chk($sformatf("%s ctl", tag), ctl_now(), 32'(v.ectl));
        if (v.ectl[1]) chk($sformatf("%s rdata_a", tag), bus.rd_a_rdata_o, v.eda);
        if (v.ectl[0]) chk($sformatf("%s rdata_b", tag), bus.rd_b_rdata_o, v.edb);
        @(posedge clk); #1;
    endtask

    // Reference model: write buffer as a queue, storage as a plain array.
    typedef struct { logic [4:0] a; logic [31:0] d; } wb_t;
    wb_t         mq[$];
    logic [31:0] mmem [32];
    bit          mpend;
    bit          m_va, m_vb;
    logic [31:0] m_da, m_db;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] r;
        r = mmem[a];
        for (int i = 0; i < mq.size(); i++) if (mq[i].a == a) r = mq[i].d;
        return (a == 5'd0) ? 32'd0 : r;
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t tbl[14];
    logic       ra, rb, w, ga, gb, wg, dr, busy_e;
    logic [4:0] aa, ba, wa;
    logic [31:0] wd;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 1, 20, 32'hDEADBEEF, 6'b001000, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b001100, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
        tbl[3]  = mk(1, 20, 0, 0, 0, 0, 0, 6'b101000, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b001010, 32'hDEADBEEF, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 5, 32'h5, 6'b001000, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 6, 32'h6, 6'b001100, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b001100, 0, 0);
        tbl[8]  = mk(1, 5, 1, 6, 0, 0, 0, 6'b101100, 0, 0);
        tbl[9]  = mk(0, 0, 1, 6, 0, 0, 0, 6'b011110, 32'h5, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 6'b001001, 0, 32'h6);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 6'b001000, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 6'b101000, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 6'b001010, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset ctl", ctl_now(), 32'd0);
        chk("reset rdata_a", bus.rd_a_rdata_o, 32'd0);
        chk("reset rdata_b", bus.rd_b_rdata_o, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Buffer fills while A reads hold the port; third write waits one forced drain.
        apply(mk(1, 1, 0, 0, 1, 7, 32'h70, 6'b101000, 0, 0), "full0");
        apply(mk(1, 2, 0, 0, 1, 8, 32'h80, 6'b101110, 0, 0), "full1");
        apply(mk(1, 3, 0, 0, 1, 9, 32'h90, 6'b000110, 0, 0), "full2");
        apply(mk(1, 3, 0, 0, 1, 9, 32'h90, 6'b101100, 0, 0), "full3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6'b000110, 0, 0), "full4");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6'b001100, 0, 0), "full5");
        apply(mk(1, 9, 0, 0, 0, 0, 0, 6'b101000, 0, 0), "full6");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6'b001010, 32'h90, 0), "full7");

        // Two writes to r9 back to back; the younger value is forwarded, then lands in the array.
        apply(mk(1, 1, 0, 0, 1, 9, 32'h11, 6'b101000, 0, 0), "fwd0");
        apply(mk(1, 2, 0, 0, 1, 9, 32'h22, 6'b101110, 0, 0), "fwd1");
        apply(mk(1, 9, 0, 0, 0, 0, 0, 6'b000110, 0, 0), "fwd2");
        apply(mk(1, 9, 0, 0, 0, 0, 0, 6'b101100, 0, 0), "fwd3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6'b001110, 32'h22, 0), "fwd4");
        apply(mk(1, 9, 0, 0, 0, 0, 0, 6'b101000, 0, 0), "fwd5");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6'b001010, 32'h22, 0), "fwd6");

        // Reset while two writes are buffered and an rvalid is pending.
        apply(mk(1, 20, 0, 0, 1, 10, 32'hA, 6'b101000, 0, 0), "rst0");
        apply(mk(1, 9, 0, 0, 1, 11, 32'hB, 6'b101110, 32'hDEADBEEF, 0), "rst1");
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("midrst ctl", ctl_now(), 32'd0);
        chk("midrst rdata_a", bus.rd_a_rdata_o, 32'd0);
        chk("midrst rdata_b", bus.rd_b_rdata_o, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        apply(mk(1, 10, 0, 0, 0, 0, 0, 6'b101000, 0, 0), "rst2");
        apply(mk(0, 0, 1, 11, 0, 0, 0, 6'b011010, 0, 0), "rst3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6'b001001, 0, 0), "rst4");

        // Random traffic against the reference model.
        do_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mmem[i] = 32'd0;
        mpend = 0; m_va = 0; m_vb = 0; m_da = 0; m_db = 0;
        ra = 0; rb = 0; w = 0; aa = 0; ba = 0; wa = 0; wd = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(ra, aa, rb, ba, w, wa, wd);
            @(negedge clk);
            ga = 0; gb = 0; dr = 0;
            if (mq.size() == WB) dr = 1;
            else if (mpend && rb) gb = 1;
            else if (ra) ga = 1;
            else if (rb) gb = 1;
            else if (mq.size() != 0) dr = 1;
            wg = (mq.size() < WB);
            busy_e = (mq.size() != 0) || (ra && !ga) || (rb && !gb) || mpend;
            chk($sformatf("rnd%0d ctl", cyc), ctl_now(), 32'({ga, gb, wg, busy_e, m_va, m_vb}));
            chk($sformatf("rnd%0d rdata_a", cyc), bus.rd_a_rdata_o, m_da);
            chk($sformatf("rnd%0d rdata_b", cyc), bus.rd_b_rdata_o, m_db);
            @(posedge clk); #1;
            if (ga) m_da = model_read(aa);
            if (gb) m_db = model_read(ba);
            m_va = ga; m_vb = gb;
            if (dr) begin
                mmem[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (w && wg && wa != 5'd0) mq.push_back('{a: wa, d: wd});
            mpend = (ga && rb) || (mpend && rb && !gb);
            if (!ra || ga) begin
                ra = ($urandom_range(0, 99) < 40);
                aa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            if (!rb || gb) begin
                rb = ($urandom_range(0, 99) < 35);
                ba = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            if (!w || wg) begin
                w  = ($urandom_range(0, 99) < 50);
                wa = 5'($urandom_range(0, 7));
                wd = $urandom;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
